// File: rtl/decode_inst_queue_if.sv
`default_nettype none
// ============================================================================
// decode_inst_queue_if : fetch/decode handshake bundle for the instruction queue
// Rev 1.0
// ============================================================================
interface decode_inst_queue_if #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_is_branch;
  logic              out_is_jal;
  logic              out_is_jalr;
  logic              out_illegal;
  logic [CW-1:0]     count;

  modport slave (
    input  flush, in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst,
           out_is_branch, out_is_jal, out_is_jalr, out_illegal, count
  );

  modport master (
    output flush, in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst,
           out_is_branch, out_is_jal, out_is_jalr, out_illegal, count
  );
endinterface
`default_nettype wire

// File: rtl/decode_inst_queue.sv
`default_nettype none
// ============================================================================
// decode_inst_queue : DEPTH-entry fetch->decode FIFO with opcode pre-decode
// Rev 1.0
// ============================================================================
module decode_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  decode_inst_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + INST_W;

  localparam logic [CW-1:0] c_depth     = CW'(DEPTH);
  localparam logic [6:0]    c_op_branch = 7'b1100011;
  localparam logic [6:0]    c_op_jal    = 7'b1101111;
  localparam logic [6:0]    c_op_jalr   = 7'b1100111;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;
  logic [6:0]    w_op;

  // in_ready looks only at registered occupancy, so a full queue never takes a
  // push in the same cycle it pops.
  assign w_in_ready  = (r_count != c_depth);
  assign w_out_valid = (r_count != '0);
  assign w_push      = q.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && q.out_ready;

  assign w_head = r_mem[r_rd_ptr];
  assign w_op   = w_head[6:0];

  assign q.in_ready      = w_in_ready;
  assign q.out_valid     = w_out_valid;
  assign q.count         = r_count;
  assign q.out_pc        = w_head[EW-1:INST_W];
  assign q.out_inst      = w_head[INST_W-1:0];
  assign q.out_is_branch = w_out_valid && (w_op == c_op_branch);
  assign q.out_is_jal    = w_out_valid && (w_op == c_op_jal);
  assign q.out_is_jalr   = w_out_valid && (w_op == c_op_jalr);
  assign q.out_illegal   = w_out_valid && (w_op[1:0] != 2'b11);

  always_ff @(posedge clk) begin
    if (reset || q.flush) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)
        r_count <= r_count - 1'b1;
    end
  end

  // Storage has no reset; a flushed push is simply not written.
  always_ff @(posedge clk) begin
    if (!reset && !q.flush && w_push)
      r_mem[r_wr_ptr] <= {q.in_pc, q.in_inst};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (r_count <= c_depth);
      assert (!(w_push && (r_count == c_depth)));
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_decode_inst_queue.sv
`default_nettype none
// ============================================================================
// tb_decode_inst_queue : directed bench with a queue-based reference model
// Rev 1.0
// ============================================================================
module tb_decode_inst_queue;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  decode_inst_queue_if #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) bus ();

  decode_inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus)
  );

  int          total = 0;
  int          bad   = 0;
  bit          chk_en = 1'b0;
  logic [63:0] mdl [$];
  bit          m_push, m_pop;
  logic [63:0] m_head;
  logic [3:0]  m_flags;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] flags_of(input logic [31:0] inst);
    return {inst[6:0] == 7'h63, inst[6:0] == 7'h6F, inst[6:0] == 7'h67, inst[1:0] != 2'b11};
  endfunction

  // Reference: an ordinary FIFO of {pc,inst} words.
  always @(posedge clk) begin
    if (reset || bus.flush) begin
      mdl.delete();
    end else begin
      m_push = bus.in_valid && (mdl.size() < DEPTH);
      m_pop  = bus.out_ready && (mdl.size() > 0);
      if (m_pop)  void'(mdl.pop_front());
      if (m_push) mdl.push_back({bus.in_pc, bus.in_inst});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 64'(bus.count), 64'(mdl.size()));
      chk("out_valid", 64'(bus.out_valid), 64'(mdl.size() != 0));
      chk("in_ready", 64'(bus.in_ready), 64'(mdl.size() != DEPTH));
      if (mdl.size() != 0) begin
        m_head  = mdl[0];
        m_flags = flags_of(m_head[31:0]);
        chk("out_pc", 64'(bus.out_pc), 64'(m_head[63:32]));
        chk("out_inst", 64'(bus.out_inst), 64'(m_head[31:0]));
      end else begin
        m_flags = 4'b0000;
      end
      chk("flags", 64'({bus.out_is_branch, bus.out_is_jal, bus.out_is_jalr, bus.out_illegal}),
          64'(m_flags));
    end
  end

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic rdy, input logic fl = 1'b0);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_inst   = inst;
    bus.out_ready = rdy;
    bus.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] dut_flags();
    return {bus.out_is_branch, bus.out_is_jal, bus.out_is_jalr, bus.out_illegal};
  endfunction

  logic [31:0] t4_inst [4] = '{32'h0000006F, 32'h00008067, 32'h00208463, 32'h00000000};
  logic [3:0]  t4_flag [4] = '{4'b0100, 4'b0010, 4'b1000, 4'b0001};

  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0; bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // single push, one-cycle latency
    step(1'b1, 32'h100, 32'h00500093, 1'b0);
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_pc", 64'(bus.out_pc), 64'h100);
    chk("t1_count", 64'(bus.count), 64'd1);
    chk("t1_flags", 64'(dut_flags()), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1);

    // fill, reject the extra offer, drain in order
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 32'h00000013, 1'b0);
    chk("t2_full_count", 64'(bus.count), 64'd4);
    chk("t2_full_ready", 64'(bus.in_ready), 64'd0);
    step(1'b1, 32'h10, 32'h00000013, 1'b0);
    chk("t2_reject_count", 64'(bus.count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_pc", 64'(bus.out_pc), 64'(i * 4));
      step(1'b0, 32'h0, 32'h0, 1'b1);
    end
    chk("t2_empty", 64'(bus.out_valid), 64'd0);

    // streaming through count=1 across several pointer wraps
    step(1'b1, 32'h200, 32'h00000013, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 32'h200 + 32'(4 * i), 32'h00000013, 1'b1);
      chk("t3_count", 64'(bus.count), 64'd1);
      chk("t3_pc", 64'(bus.out_pc), 64'(32'h200 + 32'(4 * i)));
    end
    step(1'b0, 32'h0, 32'h0, 1'b1);
    chk("t3_empty", 64'(bus.out_valid), 64'd0);

    // pre-decode flags
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h300, t4_inst[i], 1'b0);
      chk("t4_flags", 64'(dut_flags()), 64'(t4_flag[i]));
      step(1'b0, 32'h0, 32'h0, 1'b1);
    end

    // flush with concurrent push and pop
    for (int i = 0; i < 3; i++) step(1'b1, 32'h400 + 32'(4 * i), 32'h00000013, 1'b0);
    chk("t5_count3", 64'(bus.count), 64'd3);
    step(1'b1, 32'h40C, 32'h00000013, 1'b1, 1'b1);
    chk("t5_count", 64'(bus.count), 64'd0);
    chk("t5_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_ready", 64'(bus.in_ready), 64'd1);
    step(1'b1, 32'h500, 32'h00000013, 1'b0);
    chk("t5_pc", 64'(bus.out_pc), 64'h500);
    chk("t5_count1", 64'(bus.count), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    chk("t5_empty", 64'(bus.out_valid), 64'd0);

    // reset mid-stream with a push offered
    step(1'b1, 32'h600, 32'h00000013, 1'b0);
    step(1'b1, 32'h604, 32'h00000013, 1'b0);
    chk("t6_count2", 64'(bus.count), 64'd2);
    reset = 1'b1;
    step(1'b1, 32'h608, 32'h00000013, 1'b0);
    reset = 1'b0;
    chk("t6_count", 64'(bus.count), 64'd0);
    chk("t6_valid", 64'(bus.out_valid), 64'd0);
    step(1'b1, 32'h700, 32'h00000013, 1'b0);
    step(1'b1, 32'h704, 32'h00000013, 1'b0);
    chk("t6_pc0", 64'(bus.out_pc), 64'h700);
    chk("t6_count_after", 64'(bus.count), 64'd2);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    chk("t6_pc1", 64'(bus.out_pc), 64'h704);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    chk("t6_empty", 64'(bus.out_valid), 64'd0);

    step(1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
